// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and reg_write gating.
// Optional MEM_WB_STATS_EN adds free-running bubble_cnt and stall_cnt outputs.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  valid_m,
    output logic                  ready_m,
    input  logic                  wb_source_m,
    input  logic                  reg_write_m,
    input  logic [DATA_W-1:0]     alu_out_m,
    input  logic [DATA_W-1:0]     data_m,
    input  logic [REG_ADDR_W-1:0] register_d_m,
    output logic                  valid_w,
    input  logic                  ready_w,
    output logic                  wb_source_w,
    output logic                  reg_write_w,
    output logic [DATA_W-1:0]     alu_out_w,
    output logic [DATA_W-1:0]     data_w,
`ifdef MEM_WB_STATS_EN
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           stall_cnt,
`endif
    output logic [REG_ADDR_W-1:0] register_d_w
);

    typedef struct packed {
        logic                  wb_source;
        logic                  reg_write;
        logic [DATA_W-1:0]     alu_out;
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] register_d;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e   state_q, state_d;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    payload_t in_pl;
    logic     main_valid;
    logic     accept;
    logic     retire;

    assign in_pl = '{wb_source:  wb_source_m,
                     reg_write:  reg_write_m,
                     alu_out:    alu_out_m,
                     data:       data_m,
                     register_d: register_d_m};

    // Both handshake signals are decoded from the state register only, so
    // ready_m never sees ready_w combinationally.
    assign main_valid = (state_q != EMPTY);
    assign ready_m    = (state_q != TWO);
    assign accept     = valid_m & ready_m;
    assign retire     = main_valid & ready_w;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_pl;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    main_d = in_pl;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = in_pl;
                end else if (retire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (retire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Squash: drop everything; payload is held so a discarded accept never reaches the outputs.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= EMPTY;
            // NOTE: payload storage is reset because main drives outputs with defined reset values; skid matches for simplicity.
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign valid_w      = main_valid;
    assign reg_write_w  = main_q.reg_write & main_valid & (main_q.register_d != '0);
    assign wb_source_w  = main_q.wb_source;
    assign alu_out_w    = main_q.alu_out;
    assign data_w       = main_q.data;
    assign register_d_w = main_q.register_d;

`ifdef MEM_WB_STATS_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q + {31'd0, ~valid_w};
        stall_cnt_d  = stall_cnt_q + {31'd0, valid_w & ~ready_w};
    end

    // Cleared only by reset; flush leaves the statistics running.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg: queue-based model, directed cases, randomized traffic.
// Stats checks compile in only when MEM_WB_STATS_EN is defined.
module tb_mem_wb_pipe_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        valid_m;
    logic        ready_m;
    logic        wb_source_m;
    logic        reg_write_m;
    logic [31:0] alu_out_m;
    logic [31:0] data_m;
    logic [4:0]  register_d_m;
    logic        valid_w;
    logic        ready_w;
    logic        wb_source_w;
    logic        reg_write_w;
    logic [31:0] alu_out_w;
    logic [31:0] data_w;
    logic [4:0]  register_d_w;
`ifdef MEM_WB_STATS_EN
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;
    int unsigned m_bubble;
    int unsigned m_stall;
`endif

    mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .valid_m      (valid_m),
        .ready_m      (ready_m),
        .wb_source_m  (wb_source_m),
        .reg_write_m  (reg_write_m),
        .alu_out_m    (alu_out_m),
        .data_m       (data_m),
        .register_d_m (register_d_m),
        .valid_w      (valid_w),
        .ready_w      (ready_w),
        .wb_source_w  (wb_source_w),
        .reg_write_w  (reg_write_w),
        .alu_out_w    (alu_out_w),
        .data_w       (data_w),
`ifdef MEM_WB_STATS_EN
        .bubble_cnt   (bubble_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .register_d_w (register_d_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wb_source;
        bit          reg_write;
        logic [31:0] alu_out;
        logic [31:0] data;
        logic [4:0]  register_d;
    } entry_t;

    entry_t q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic entry_t cur_in();
        entry_t e;
        e.wb_source  = wb_source_m;
        e.reg_write  = reg_write_m;
        e.alu_out    = alu_out_m;
        e.data       = data_m;
        e.register_d = register_d_m;
        return e;
    endfunction

    // Expected outputs follow from the FIFO contents alone.
    task automatic compare();
        check_b("valid_w", valid_w, q.size() > 0);
        check_b("ready_m", ready_m, q.size() < 2);
        if (q.size() > 0) begin
            check_b("reg_write_w", reg_write_w, q[0].reg_write && (q[0].register_d != 5'd0));
            check_b("wb_source_w", wb_source_w, q[0].wb_source);
            check_w("alu_out_w", alu_out_w, q[0].alu_out);
            check_w("data_w", data_w, q[0].data);
            check_w("register_d_w", 32'(register_d_w), 32'(q[0].register_d));
        end else begin
            check_b("reg_write_w_bubble", reg_write_w, 1'b0);
        end
`ifdef MEM_WB_STATS_EN
        check_w("bubble_cnt", bubble_cnt, m_bubble);
        check_w("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    // Called at a falling edge with inputs already driven; advances one clock.
    task automatic step();
        bit acc;
        bit ret;
        if (!reset) compare();
        if (reset) begin
            q.delete();
`ifdef MEM_WB_STATS_EN
            m_bubble = 0;
            m_stall  = 0;
`endif
        end else begin
`ifdef MEM_WB_STATS_EN
            if (q.size() == 0) m_bubble++;
            else if (!ready_w) m_stall++;
`endif
            acc = valid_m && (q.size() < 2);
            ret = (q.size() > 0) && ready_w;
            if (flush) begin
                q.delete();
            end else begin
                if (ret) void'(q.pop_front());
                if (acc) q.push_back(cur_in());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] alu, input logic [4:0] rd, input bit rw);
        valid_m      = v;
        alu_out_m    = alu;
        data_m       = ~alu;
        register_d_m = rd;
        reg_write_m  = rw;
        wb_source_m  = alu[0];
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        ready_w = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);

        // Reset held two cycles
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        check_b("rst_valid_w", valid_w, 1'b0);
        check_b("rst_reg_write_w", reg_write_w, 1'b0);
        check_w("rst_alu_out_w", alu_out_w, 32'h0);
        check_b("rst_ready_m", ready_m, 1'b1);

        // Streaming with ready_w high
        ready_w = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h10 * (k + 1), 5'd3, 1'b1);
            step();
            check_w("stream_alu", alu_out_w, 32'h10 * (k + 1));
            check_b("stream_ready_m", ready_m, 1'b1);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();

        // Skid fill with ready_w low
        ready_w = 1'b0;
        drive(1'b1, 32'hA, 5'd7, 1'b1);
        step();
        drive(1'b1, 32'hB, 5'd8, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check_b("skid_ready_m", ready_m, 1'b0);
        check_b("skid_valid_w", valid_w, 1'b1);
        check_w("skid_head", alu_out_w, 32'hA);
        ready_w = 1'b1;
        step();
        check_w("skid_second", alu_out_w, 32'hB);
        check_b("skid_ready_back", ready_m, 1'b1);
        step();

        // Flush in TWO with a simultaneous offer
        ready_w = 1'b0;
        drive(1'b1, 32'hA, 5'd7, 1'b1);
        step();
        drive(1'b1, 32'hB, 5'd8, 1'b1);
        step();
        flush = 1'b1;
        drive(1'b1, 32'hC, 5'd9, 1'b1);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check_b("flush_valid_w", valid_w, 1'b0);
        check_b("flush_reg_write_w", reg_write_w, 1'b0);
        check_b("flush_ready_m", ready_m, 1'b1);
        ready_w = 1'b1;
        step();
        step();

        // $zero guard
        drive(1'b1, 32'h55, 5'd0, 1'b1);
        step();
        check_b("zero_valid", valid_w, 1'b1);
        check_b("zero_reg_write", reg_write_w, 1'b0);
        drive(1'b1, 32'h66, 5'd5, 1'b1);
        step();
        check_b("r5_reg_write", reg_write_w, 1'b1);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();

`ifdef MEM_WB_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        ready_w = 1'b0;
        repeat (3) step();
        drive(1'b1, 32'h77, 5'd2, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        step();
        check_b("bubble_ge3", bubble_cnt >= 32'd3, 1'b1);
        check_w("stall_two", stall_cnt, 32'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_b("flush_keeps_bubble", bubble_cnt >= 32'd3, 1'b1);
        check_b("flush_keeps_stall", stall_cnt >= 32'd2, 1'b1);
        step();
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            valid_m      = $urandom_range(0, 2) != 0;
            ready_w      = $urandom_range(0, 2) != 0;
            wb_source_m  = $urandom_range(0, 1) != 0;
            reg_write_m  = $urandom_range(0, 3) != 0;
            alu_out_m    = $urandom;
            data_m       = $urandom;
            register_d_m = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
